// File: rtl/xercr_track.sv
// Architectural XERCR plus an in-order queue of speculative XERCR results from EXE.
// Entries retire oldest-first on writeback commit and are all discarded on flush.
module xercr_track #(
    parameter int               WIDTH     = 40,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exe_valid,
    output logic             exe_ready,
    input  logic             exe_rc_write,
    input  logic [WIDTH-1:0] exe_rc,
    input  logic             wb_commit,
    input  logic             flush,
    output logic [WIDTH-1:0] rc_cur,
    output logic [WIDTH-1:0] rc_committed,
    output logic [2:0]       pending,
    output logic             commit_err
);

    localparam logic [1:0] LAST = 2'(DEPTH - 1);
    localparam logic [2:0] FULL = 3'(DEPTH);

    // Storage is always 4 deep so the 2-bit pointers index it for any DEPTH.
    logic [WIDTH-1:0] mem [4];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [1:0]       young_ptr;
    logic [2:0]       count;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] entry;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // exe_ready depends only on the count register, never on wb_commit/flush.
    assign exe_ready = (count != FULL);
    assign push      = exe_valid & exe_ready & ~flush;
    assign pop       = wb_commit & (count != 3'd0);
    assign young_ptr = (wr_ptr == 2'd0) ? LAST : wr_ptr - 2'd1;
    assign rc_cur    = (count != 3'd0) ? mem[young_ptr] : rc_committed;
    // A non-writing instruction still occupies a slot, carrying the value it saw.
    assign entry     = exe_rc_write ? exe_rc : rc_cur;
    assign pending   = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc_committed <= RESET_VAL;
            rd_ptr       <= 2'd0;
            wr_ptr       <= 2'd0;
            count        <= 3'd0;
            commit_err   <= 1'b0;
        end else begin
            commit_err <= wb_commit & (count == 3'd0);
            if (pop) begin
                rc_committed <= mem[rd_ptr];
            end
            // Flush keeps a same-cycle commit, then empties the queue.
            if (flush) begin
                rd_ptr <= 2'd0;
                wr_ptr <= 2'd0;
                count  <= 3'd0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count + {2'b00, push} - {2'b00, pop};
            end
        end
    end

`ifdef SIM
    always_ff @(posedge clk) begin
        if (!reset && wb_commit && count == 3'd0) begin
            $fatal(1, "xercr_track: wb_commit with empty queue");
        end
    end
`endif

endmodule
